// File: rtl/acc_core.sv
// Parametrised multicycle accumulator core: FETCH/EXEC/MEM/HALT over req/ack memories.
// Optional multiplier for opcode 16 is built only when ACC_CORE_MUL_EN is defined.
module acc_core #(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned OPND_W   = 12,
    parameter int unsigned NUM_REGS = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   im_addr,
    output logic                im_req,
    input  logic                im_ack,
    input  logic [OPND_W+4:0]   im_rdata,
    output logic [ADDR_W-1:0]   dm_addr,
    output logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_we,
    output logic                dm_req,
    input  logic                dm_ack,
    input  logic [DATA_W-1:0]   dm_rdata,
    output logic [DATA_W-1:0]   acc_out,
    output logic                flag_z,
    output logic                flag_n,
    output logic                halted
);

    localparam int unsigned INSTR_W = 5 + OPND_W;
    localparam int unsigned K_W     = $clog2(NUM_REGS);

    localparam logic [4:0] OP_LDI   = 5'd1;
    localparam logic [4:0] OP_LOAD  = 5'd2;
    localparam logic [4:0] OP_STORE = 5'd3;
    localparam logic [4:0] OP_MOVR  = 5'd4;
    localparam logic [4:0] OP_MOVA  = 5'd5;
    localparam logic [4:0] OP_ADD   = 5'd6;
    localparam logic [4:0] OP_SUB   = 5'd7;
    localparam logic [4:0] OP_AND   = 5'd8;
    localparam logic [4:0] OP_OR    = 5'd9;
    localparam logic [4:0] OP_XOR   = 5'd10;
    localparam logic [4:0] OP_INC   = 5'd11;
    localparam logic [4:0] OP_CLR   = 5'd12;
    localparam logic [4:0] OP_JMP   = 5'd13;
    localparam logic [4:0] OP_JZ    = 5'd14;
    localparam logic [4:0] OP_JN    = 5'd15;
`ifdef ACC_CORE_MUL_EN
    localparam logic [4:0] OP_MUL   = 5'd16;
`endif
    localparam logic [4:0] OP_HALT  = 5'd31;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic [DATA_W-1:0]      ac_q, ac_d;
    logic [INSTR_W-1:0]     ir_q, ir_d;
    logic [NUM_REGS-1:0]    reg_we;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;

    logic [4:0]             opcode;
    logic [OPND_W-1:0]      opnd;
    logic [K_W-1:0]         k;
    logic [DATA_W-1:0]      rk;
    logic                   is_store;

    assign opcode   = ir_q[INSTR_W-1 -: 5];
    assign opnd     = ir_q[OPND_W-1:0];
    assign k        = opnd[K_W-1:0];
    assign rk       = regs_flat[int'(k)*DATA_W +: DATA_W];
    assign is_store = (opcode == OP_STORE);

`ifdef ACC_CORE_MUL_EN
    logic [DATA_W-1:0] mul_lo;
    assign mul_lo = ac_q * rk;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] r_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                end else if (reg_we[gi]) begin
                    r_q <= ac_q;
                end
            end
            assign regs_flat[gi*DATA_W +: DATA_W] = r_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ac_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ac_q    <= ac_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ac_d    = ac_q;
        ir_d    = ir_q;
        reg_we  = '0;
        unique case (state_q)
            S_FETCH: begin
                if (im_ack) begin
                    ir_d    = im_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_LDI:   ac_d = DATA_W'(opnd);
                    OP_LOAD,
                    OP_STORE: state_d = S_MEM;
                    OP_MOVR:  reg_we[k] = 1'b1;
                    OP_MOVA:  ac_d = rk;
                    OP_ADD:   ac_d = ac_q + rk;
                    OP_SUB:   ac_d = ac_q - rk;
                    OP_AND:   ac_d = ac_q & rk;
                    OP_OR:    ac_d = ac_q | rk;
                    OP_XOR:   ac_d = ac_q ^ rk;
                    OP_INC:   ac_d = ac_q + DATA_W'(1);
                    OP_CLR:   ac_d = '0;
                    OP_JMP:   pc_d = opnd[ADDR_W-1:0];
                    OP_JZ:    if (flag_z) pc_d = opnd[ADDR_W-1:0];
                    OP_JN:    if (flag_n) pc_d = opnd[ADDR_W-1:0];
`ifdef ACC_CORE_MUL_EN
                    OP_MUL:   ac_d = mul_lo;
`endif
                    OP_HALT:  state_d = S_HALT;
                    default:  ;
                endcase
            end
            S_MEM: begin
                // Address/data stay driven from IR and AC, so they are stable until ack.
                if (dm_ack) begin
                    if (!is_store) ac_d = dm_rdata;
                    state_d = S_FETCH;
                end
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
    end

    // Requests come from state only; gating with rst drops them the moment reset rises.
    assign im_req   = (state_q == S_FETCH) && !rst;
    assign dm_req   = (state_q == S_MEM) && !rst;
    assign dm_we    = dm_req && is_store;
    assign im_addr  = pc_q;
    assign dm_addr  = opnd[ADDR_W-1:0];
    assign dm_wdata = ac_q;
    assign acc_out  = ac_q;
    assign flag_z   = (ac_q == '0);
    assign flag_n   = ac_q[DATA_W-1];
    assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_acc_core.sv
// Self-checking bench for acc_core: instruction-level reference model, randomized wait states,
// spurious acks and randomized programs, plus directed programs with literal expectations.
module tb_acc_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] im_addr;
    logic        im_req;
    logic        im_ack = 1'b0;
    logic [16:0] im_rdata = '0;
    logic [11:0] dm_addr;
    logic [11:0] dm_wdata;
    logic        dm_we;
    logic        dm_req;
    logic        dm_ack = 1'b0;
    logic [11:0] dm_rdata = '0;
    logic [11:0] acc_out;
    logic        flag_z, flag_n, halted;

    always #5 clk = ~clk;

    acc_core #(.DATA_W(12), .ADDR_W(12), .OPND_W(12), .NUM_REGS(4)) dut (
        .clk(clk), .rst(rst),
        .im_addr(im_addr), .im_req(im_req), .im_ack(im_ack), .im_rdata(im_rdata),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_req(dm_req),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .acc_out(acc_out), .flag_z(flag_z), .flag_n(flag_n), .halted(halted)
    );

    logic [16:0] rom  [4096];
    logic [11:0] ram  [4096];
    logic [11:0] mram [4096];
    logic [11:0] m_pc, m_ac;
    logic [11:0] m_r [4];
    bit          m_halted;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          fetch_cyc[$];
    logic [11:0] fetch_addr[$];
    int          dm_hi[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] ins(input int op, input int opnd);
        return {op[4:0], opnd[11:0]};
    endfunction

    // One whole instruction at a time, straight from the instruction-set rules.
    task automatic model_exec(input logic [16:0] instr, output bit mem, output bit we,
                              output logic [11:0] a, output logic [11:0] wd);
        logic [4:0]  op;
        logic [11:0] o;
        logic [1:0]  k;
        op = instr[16:12];
        o  = instr[11:0];
        k  = o[1:0];
        mem = 1'b0; we = 1'b0; a = o; wd = m_ac;
        m_pc = m_pc + 12'd1;
        case (op)
            5'd1:  m_ac = o;
            5'd2:  begin mem = 1'b1; m_ac = mram[o]; end
            5'd3:  begin mem = 1'b1; we = 1'b1; mram[o] = m_ac; end
            5'd4:  m_r[k] = m_ac;
            5'd5:  m_ac = m_r[k];
            5'd6:  m_ac = m_ac + m_r[k];
            5'd7:  m_ac = m_ac - m_r[k];
            5'd8:  m_ac = m_ac & m_r[k];
            5'd9:  m_ac = m_ac | m_r[k];
            5'd10: m_ac = m_ac ^ m_r[k];
            5'd11: m_ac = m_ac + 12'd1;
            5'd12: m_ac = 12'd0;
            5'd13: m_pc = o;
            5'd14: if (m_ac == 12'd0) m_pc = o;
            5'd15: if (m_ac[11]) m_pc = o;
`ifdef ACC_CORE_MUL_EN
            5'd16: m_ac = m_ac * m_r[k];
`endif
            5'd31: m_halted = 1'b1;
            default: ;
        endcase
    endtask

    task automatic run(input int n_instr, input int fmin, input int fmax,
                       input int dmin, input int dmax, input bit spur);
        int cyc, last_fetch, n_done, halt_cyc, halt_seen;
        int im_wait, im_wcnt, dm_wait, dm_wcnt, dm_cnt, prev_dw;
        bit im_busy, dm_busy, mem_pend, exp_we, prev_mem, first, done;
        logic [11:0] exp_addr, exp_wdata;

        @(negedge clk);
        rst = 1'b1; im_ack = 1'b0; dm_ack = 1'b0; im_rdata = '0; dm_rdata = '0;
        #1;
        chk("rst_im_req", im_req, 0);    chk("rst_dm_req", dm_req, 0);
        chk("rst_dm_we", dm_we, 0);      chk("rst_im_addr", im_addr, 0);
        chk("rst_dm_addr", dm_addr, 0);  chk("rst_dm_wdata", dm_wdata, 0);
        chk("rst_acc", acc_out, 0);      chk("rst_flag_z", flag_z, 1);
        chk("rst_flag_n", flag_n, 0);    chk("rst_halted", halted, 0);
        @(negedge clk);
        rst = 1'b0;
        m_pc = '0; m_ac = '0; m_halted = 1'b0;
        for (int i = 0; i < 4; i++) m_r[i] = '0;
        for (int i = 0; i < 4096; i++) mram[i] = ram[i];
        fetch_cyc.delete(); fetch_addr.delete(); dm_hi.delete();
        last_fetch = 0; n_done = 0; halt_cyc = 0; halt_seen = 0;
        im_wait = 0; im_wcnt = 0; dm_wait = 0; dm_wcnt = 0; dm_cnt = 0; prev_dw = 0;
        im_busy = 0; dm_busy = 0; mem_pend = 0; exp_we = 0; prev_mem = 0; first = 1; done = 0;
        exp_addr = '0; exp_wdata = '0;
        #1;
        for (cyc = 0; cyc < n_instr * 40 + 200 && !done; cyc++) begin
            im_ack = 1'b0; dm_ack = 1'b0;
            chk("req_exclusive", im_req & dm_req, 0);
            chk("dm_req_unexpected", dm_req & ~mem_pend, 0);
            if (m_halted && cyc - halt_cyc >= 2) begin
                chk("halt_flag", halted, 1);
                chk("halt_im_req", im_req, 0);
                chk("halt_dm_req", dm_req, 0);
                chk("halt_pc", im_addr, m_pc);
                chk("halt_acc", acc_out, m_ac);
                halt_seen++;
                if (halt_seen == 20) done = 1;
            end
            if (dm_req) begin
                dm_cnt++;
                chk("dm_addr", dm_addr, exp_addr);
                chk("dm_we", dm_we, exp_we);
                chk("dm_wdata", dm_wdata, exp_wdata);
                if (!dm_busy) begin
                    dm_busy = 1; dm_wait = $urandom_range(dmax, dmin); dm_wcnt = dm_wait;
                end
                dm_rdata = ram[dm_addr];
                if (dm_wcnt == 0) begin
                    dm_ack = 1'b1;
                    if (dm_we) ram[dm_addr] = dm_wdata;
                    dm_busy = 0; mem_pend = 0; prev_dw = dm_wait;
                    dm_hi.push_back(dm_cnt); dm_cnt = 0;
                end else begin
                    dm_wcnt--;
                end
            end else if (spur) begin
                dm_ack = 1'($urandom_range(1, 0)); dm_rdata = 12'($urandom);
            end
            if (im_req) begin
                if (!im_busy) begin
                    im_busy = 1; im_wait = $urandom_range(fmax, fmin); im_wcnt = im_wait;
                end
                im_rdata = rom[im_addr];
                if (im_wcnt == 0) begin
                    im_ack = 1'b1; im_busy = 0;
                    chk("fetch_pc", im_addr, m_pc);
                    chk("fetch_acc", acc_out, m_ac);
                    chk("fetch_flag_z", flag_z, (m_ac == 12'd0));
                    chk("fetch_flag_n", flag_n, m_ac[11]);
                    chk("fetch_halted", halted, 0);
                    if (!first)
                        chk("instr_cycles", cyc - last_fetch,
                            2 + im_wait + (prev_mem ? 1 + prev_dw : 0));
                    first = 0; last_fetch = cyc;
                    fetch_cyc.push_back(cyc); fetch_addr.push_back(im_addr);
                    model_exec(rom[m_pc], prev_mem, exp_we, exp_addr, exp_wdata);
                    mem_pend = prev_mem;
                    if (m_halted) halt_cyc = cyc;
                    n_done++;
                    if (n_done >= n_instr && !m_halted) done = 1;
                end else begin
                    im_wcnt--;
                end
            end else if (spur) begin
                im_ack = 1'($urandom_range(1, 0)); im_rdata = 17'($urandom);
            end
            @(negedge clk); #1;
        end
        chk("run_completed", done, 1);
        im_ack = 1'b0; dm_ack = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = '0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 12'($urandom);
        clear_rom();

        // Reset in the middle of an unanswered fetch.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("midfetch_im_req", im_req, 1);
            chk("midfetch_im_addr", im_addr, 0);
            @(negedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("midfetch_rst_im_req", im_req, 0);
        chk("midfetch_rst_dm_req", dm_req, 0);

        // LDI 5, MOVR R1, LDI 0xFFE, ADD R1
        clear_rom();
        rom[0] = ins(1, 5); rom[1] = ins(4, 1); rom[2] = ins(1, 12'hFFE);
        rom[3] = ins(6, 1); rom[4] = ins(31, 0);
        run(100, 0, 0, 0, 0, 0);
        chk("p1_acc", acc_out, 12'h003);
        chk("p1_flag_z", flag_z, 0);
        chk("p1_flag_n", flag_n, 0);
        chk("p1_cycles", fetch_cyc[4] - fetch_cyc[0], 8);

        // STORE/LOAD with two data wait states.
        clear_rom();
        rom[0] = ins(1, 12'h0A5); rom[1] = ins(3, 12'h010); rom[2] = ins(12, 0);
        rom[3] = ins(2, 12'h010); rom[4] = ins(31, 0);
        run(100, 0, 0, 2, 2, 0);
        chk("mem_store_req_cycles", dm_hi[0], 3);
        chk("mem_load_req_cycles", dm_hi[1], 3);
        chk("mem_ram_written", ram[16], 12'h0A5);
        chk("mem_acc", acc_out, 12'h0A5);

        // Branches, with fetch waits and spurious acks.
        clear_rom();
        rom[0] = ins(12, 0); rom[1] = ins(14, 12'h020);
        rom[12'h020] = ins(1, 1); rom[12'h021] = ins(14, 12'h040);
        rom[12'h022] = ins(1, 12'h800); rom[12'h023] = ins(15, 12'h050);
        rom[12'h050] = ins(31, 0);
        run(100, 0, 2, 0, 0, 1);
        chk("br_jz_taken", fetch_addr[2], 12'h020);
        chk("br_jz_fallthru", fetch_addr[4], 12'h022);
        chk("br_jn_taken", fetch_addr[6], 12'h050);
        chk("br_acc", acc_out, 12'h800);

        // HALT at address 7.
        clear_rom();
        rom[7] = ins(31, 0);
        run(100, 0, 1, 0, 0, 1);
        chk("halt7_pc", im_addr, 12'h008);
        chk("halt7_halted", halted, 1);

        // MUL: 0x040 * 0x041 keeps low bits 0x040; as NOP AC is also 0x040.
        clear_rom();
        rom[0] = ins(1, 12'h041); rom[1] = ins(4, 0); rom[2] = ins(1, 12'h040);
        rom[3] = ins(16, 0); rom[4] = ins(31, 0);
        run(100, 0, 0, 0, 0, 0);
        chk("mul_acc", acc_out, 12'h040);

        // Randomized programs.
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4096; i++) begin
                int op, o;
                op = ($urandom_range(99, 0) < 5) ? $urandom_range(30, 17) : $urandom_range(16, 0);
                o  = $urandom_range(4095, 0);
                if (op == 2 || op == 3) o = o & 15;
                rom[i] = ins(op, o);
            end
            run(300, 0, r % 4, 0, (r + 1) % 4, (r % 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
